// File: rtl/mem_stage_lsu_ctrl.sv
// RV32 memory-stage load/store controller: decode, lane steering, load extension, wait timeout.
// Optional MISALIGN_SPLIT_EN splits word-crossing accesses into two beats instead of flagging them.
module mem_stage_lsu_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       inst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata_in,
    output logic              stall_out,
    output logic              done,
    output logic [2:0]        whb,
    output logic [31:0]       rdata_out,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {StIdle, StReq, StReqLo, StReqHi, StResp, StErr} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              store_q;
    logic [2:0]        whb_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        be64_q;
    logic [63:0]       wd64_q;
    logic [31:0]       lo_q, hi_q;
    logic              mis_q;

    logic        is_load, is_store, is_mem, accept;
    logic [2:0]  dec_whb;
    logic [3:0]  mask;
    logic [7:0]  be64;
    logic [63:0] wd64;
    logic        mis_next, split_next;
    logic [31:0] rd32;
    logic        unused_inst;

    assign unused_inst = ^{inst[31:15], inst[11:7]};

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        dec_whb  = 3'd0;
        if (inst[6:0] == 7'b0000011) begin
            case (inst[14:12])
                3'b000:  begin is_load = 1'b1; dec_whb = 3'd0; end
                3'b001:  begin is_load = 1'b1; dec_whb = 3'd1; end
                3'b010:  begin is_load = 1'b1; dec_whb = 3'd2; end
                3'b100:  begin is_load = 1'b1; dec_whb = 3'd3; end
                3'b101:  begin is_load = 1'b1; dec_whb = 3'd4; end
                default: ;
            endcase
        end else if (inst[6:0] == 7'b0100011) begin
            case (inst[14:12])
                3'b000:  begin is_store = 1'b1; dec_whb = 3'd0; end
                3'b001:  begin is_store = 1'b1; dec_whb = 3'd1; end
                3'b010:  begin is_store = 1'b1; dec_whb = 3'd2; end
                default: ;
            endcase
        end
    end

    assign is_mem = is_load | is_store;
    assign accept = (state_q == StIdle) & valid_in & is_mem;

    always_comb begin
        case (dec_whb)
            3'd1, 3'd4: mask = 4'b0011;
            3'd2:       mask = 4'b1111;
            default:    mask = 4'b0001;
        endcase
    end

    assign be64 = {4'b0000, mask} << addr[1:0];
    assign wd64 = {32'h0, wdata_in} << {addr[1:0], 3'b000};

`ifdef MISALIGN_SPLIT_EN
    // Any byte landing in the upper word means the access straddles two words.
    assign split_next = |be64[7:4];
    assign mis_next   = 1'b0;
`else
    assign split_next = 1'b0;
    assign mis_next   = ((mask == 4'b0011) && addr[0]) ||
                        ((mask == 4'b1111) && (addr[1:0] != 2'b00));
`endif

    assign rd32 = 32'({hi_q, lo_q} >> {off_q, 3'b000});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_out = 1'b0;
        done      = 1'b0;
        misalign  = 1'b0;
        bus_err   = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        rdata_out = 32'h0;
        case (state_q)
            StIdle: begin
                if (valid_in && is_mem && !rst) begin
                    stall_out = 1'b1;
                    if (mis_next)        state_d = StResp;
                    else if (split_next) state_d = StReqLo;
                    else                 state_d = StReq;
                end
            end
            StReq, StReqLo, StReqHi: begin
                stall_out = 1'b1;
                mem_req   = 1'b1;
                if (state_q == StReqHi) begin
                    mem_addr  = base_q + ADDR_W'(4);
                    mem_be    = be64_q[7:4];
                    mem_wdata = wd64_q[63:32];
                end else begin
                    mem_addr  = base_q;
                    mem_be    = be64_q[3:0];
                    mem_wdata = wd64_q[31:0];
                end
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = (state_q == StReqLo) ? StReqHi : StResp;
                end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
                    cnt_d   = '0;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                done     = 1'b1;
                misalign = mis_q;
                if (!store_q && !mis_q) begin
                    case (whb_q)
                        3'd0:    rdata_out = {{24{rd32[7]}}, rd32[7:0]};
                        3'd1:    rdata_out = {{16{rd32[15]}}, rd32[15:0]};
                        3'd2:    rdata_out = rd32;
                        3'd3:    rdata_out = {24'h0, rd32[7:0]};
                        3'd4:    rdata_out = {16'h0, rd32[15:0]};
                        default: rdata_out = 32'h0;
                    endcase
                end
                state_d = StIdle;
            end
            StErr: begin
                done    = 1'b1;
                bus_err = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_we = mem_req & store_q;
    assign whb    = whb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            store_q <= 1'b0;
            whb_q   <= 3'd0;
            off_q   <= 2'd0;
            base_q  <= '0;
            be64_q  <= 8'h0;
            wd64_q  <= 64'h0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                store_q <= is_store;
                whb_q   <= dec_whb;
                off_q   <= addr[1:0];
                base_q  <= {addr[ADDR_W-1:2], 2'b00};
                be64_q  <= be64;
                wd64_q  <= wd64;
                lo_q    <= 32'h0;
                hi_q    <= 32'h0;
                mis_q   <= mis_next;
            end
            if (mem_req && mem_ready) begin
                if (state_q == StReqHi) hi_q <= mem_rdata;
                else                    lo_q <= mem_rdata;
            end
        end
    end

endmodule
